// File: rtl/store_sequencer.sv
// -----------------------------------------------------------------------------
// store_sequencer
//
// Multicycle controller that sequences SW/SH/SB memory stores. A full-word
// store (SW) goes straight to a write. A sub-word store (SH/SB) does a
// read-modify-write: it reads the aligned word, merges the half or byte into
// the right lane (little-endian), and writes the merged word back. The
// write-data mux select (wd_sel) picks either register B or the merged word.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   : SW with addr[1:0]!=0 and SH with addr[0]==1 go to ERR.
//   undefined : misalignment is ignored; only store_type==2'b11 produces err.
//
// Parameters:
//   MEM_LATENCY  read latency in cycles from mem_re to valid mem_rdata (1..4)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, sampled only in IDLE
//   store_type   00=SW, 01=SH, 10=SB, 11=reserved
//   addr         byte address of the store
//   b_data       register B value (store source)
//   mem_rdata    memory read data
//   mem_addr     word-aligned store address
//   mem_re       memory read strobe
//   mem_we       memory write strobe
//   wd_sel       write-data mux select (0=B, 1=merged)
//   merged_data  read-modify-write result
//   busy         high whenever not in IDLE
//   done         one-cycle completion pulse
//   err          one-cycle pulse on an illegal or trapped request
// -----------------------------------------------------------------------------
module store_sequencer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic        wd_sel,
  output logic [31:0] merged_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] TYPE_SW = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SB = 2'b10;
  localparam logic [1:0] TYPE_RS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] b_q;
  logic [1:0]  type_q;
  logic [31:0] merged_q;
  logic        wd_sel_q;
  logic        misaligned;
  logic        last_wait;

  // Misalignment is judged on the live inputs because it only matters on the
  // cycle start is accepted in IDLE.
`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = ((store_type == TYPE_SW) && (addr[1:0] != 2'b00)) ||
                      ((store_type == TYPE_SH) && addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  // WAIT lasts exactly MEM_LATENCY cycles: the counter enters at MEM_LATENCY
  // and the last WAIT cycle is the one where it reads 1.
  assign last_wait = (state_q == S_WAIT) && (wait_cnt_q == 3'd1);

  // Little-endian lane merge of the latched B operand into the read word.
  function automatic logic [31:0] merge_word(input logic [1:0]  t,
                                             input logic [1:0]  lane,
                                             input logic [31:0] b,
                                             input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata;
    case (t)
      TYPE_SB: w[{lane, 3'b000} +: 8]   = b[7:0];
      TYPE_SH: w[{lane[1], 4'b0000} +: 16] = b[15:0];
      TYPE_SW: w = b;
      default: w = rdata;
    endcase
    return w;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((store_type == TYPE_RS) || misaligned) state_d = S_ERR;
          else if (store_type == TYPE_SW)            state_d = S_WRITE;
          else                                       state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (last_wait) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
      addr_q     <= 32'd0;
      b_q        <= 32'd0;
      type_q     <= TYPE_SW;
      merged_q   <= 32'd0;
      wd_sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && start) begin
        addr_q <= addr;
        b_q    <= b_data;
        type_q <= store_type;
      end

      if (state_q == S_READ)      wait_cnt_q <= 3'(MEM_LATENCY);
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q - 3'd1;

      if (last_wait) merged_q <= merge_word(type_q, addr_q[1:0], b_q, mem_rdata);

      // WRITE is entered either straight from IDLE (SW, selects B) or from
      // WAIT (sub-word, selects merged); the select then holds until the
      // next request reaches WRITE.
      if ((state_d == S_WRITE) && (state_q != S_WRITE)) wd_sel_q <= (state_q == S_WAIT);
    end
  end

  // Outputs come only from registers or state decode, so reset drops the
  // strobes immediately and no input reaches an output combinationally.
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_re      = (state_q == S_READ);
  assign mem_we      = (state_q == S_WRITE);
  assign wd_sel      = wd_sel_q;
  assign merged_data = merged_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);

endmodule
